ad7606_emu: RTL and testbench
=============================

AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 Parameter P_BUSY_CYCLES, default 200, base conversion time in i_clk cycles (4 us at 50 MHz).
REQ-002 Parameter P_DATA_W, default 16, sample width; fixed at 16 for this revision.
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_ad_convstA / i_ad_convstB  input  1 each  conversion start from driver.
REQ-006 i_ad_reset  input  1  device reset pin, active-high.
REQ-007 i_ad_stby  input  1  standby pin; 0 = standby, 1 = normal.
REQ-008 i_ad_cs / i_ad_rd  input  1 each  parallel-read chip select and read strobe, both active-low.
REQ-009 i_ad_osc  input  3  oversampling ratio select.
REQ-010 i_ad_range, i_ad_psb_sel  input  1 each  accepted, no functional effect.
REQ-011 o_ad_busy  output  1  conversion in progress.
REQ-012 o_ad_data  output  16  parallel data bus (0 when not driven).
REQ-013 o_ad_frstdata  output  1  high while channel 1 is on the bus.

Function
REQ-014 All inputs are synchronous to i_clk; the block SHALL register i_ad_convstA&i_ad_convstB and i_ad_rd once for edge detection.
REQ-015 States: IDLE, CONV, READY, DEVRST, STBY.
REQ-016 Start event = rising edge of (convstA & convstB); in IDLE or READY it SHALL enter CONV on the next cycle, set o_ad_busy=1, clear read pointer to 0.
REQ-017 Conversion time = P_BUSY_CYCLES << i_ad_osc for osc 0..6, latched at start; osc=7 SHALL be treated as 0.
REQ-018 Busy counter counts down from conversion time; on reaching 1 the next cycle SHALL set o_ad_busy=0, increment 13-bit frame counter (wraps 8191->0) and enter READY.
REQ-019 Start event during CONV SHALL be ignored (no restart, no time extension).
REQ-020 Sample for channel n (0..7) SHALL be {n[2:0], frame_cnt[12:0]} using the post-increment frame count.
REQ-021 Read pointer (0..8) SHALL increment on each i_ad_rd rising edge while i_ad_cs=0 in READY; it saturates at 8.
REQ-022 o_ad_data registered: sample[ptr] when state READY, cs=0, rd=0, ptr<8; otherwise 16'h0000 (one cycle latency from rd low).
REQ-023 o_ad_frstdata registered: 1 exactly when o_ad_data condition holds with ptr=0.
REQ-024 Reads in IDLE or CONV SHALL return 0 and not move the pointer.
REQ-025 i_ad_reset=1 in any state SHALL enter DEVRST: busy=0, data=0, ptr=0, frame_cnt=0, abort conversion; exit to IDLE the cycle after i_ad_reset=0.
REQ-026 i_ad_stby=0 (and i_ad_reset=0) SHALL enter STBY: conversions aborted, start events ignored, busy=0; return to IDLE on i_ad_stby=1, frame_cnt retained.
REQ-027 Priority per cycle: i_rst > i_ad_reset > standby > start > busy countdown > read.
REQ-028 Start and rd rising edge in the same READY cycle: start wins; pointer cleared to 0.

Reset
REQ-029 On i_rst=1 the block SHALL hold IDLE with o_ad_busy=0, o_ad_data=0, o_ad_frstdata=0, ptr=0, frame_cnt=0, edge registers=0.
REQ-030 i_rst asserted mid-conversion or mid-read SHALL take effect on the next clock edge with the above values.

Verification
REQ-031 osc=0, convst A&B rise -> busy high next cycle, exactly 200 cycles, then low; frame_cnt=1.
REQ-032 After REQ-031, cs=0 and 8 rd low/high pulses -> data 16'h0001,16'h2001,...,16'hE001; frstdata only on the first; 9th read returns 0.
REQ-033 osc=3 start -> busy high for 1600 cycles; second convst 100 cycles in -> ignored, busy still 1600 total.
REQ-034 i_ad_reset pulsed 2 cycles at busy cycle 50 -> busy=0 next cycle, state IDLE, following conversion yields frame_cnt=1 (data 16'h0001 on ch1).
REQ-035 stby=0 then convst edge -> busy stays 0; stby=1 then convst -> normal 200-cycle busy.
REQ-036 8191 conversions then one more -> ch1 data 16'h0000 (frame counter wrap).

Source files
------------

// File: rtl/ad7606_emu.sv
// Cycle-level emulation of the AD7606 conversion/parallel-read handshake.
// Synthetic samples are {channel, frame counter} so reads are self-identifying.
//
// state  | meaning
// IDLE   | powered, no conversion result available
// CONV   | conversion running, busy high, down-counter active
// READY  | result frame available for parallel reads
// DEVRST | device reset pin asserted
// STBY   | standby, conversions blocked
module ad7606_emu #(
    parameter int unsigned P_BUSY_CYCLES = 200,
    parameter int unsigned P_DATA_W      = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ad_convstA,
    input  logic                i_ad_convstB,
    input  logic                i_ad_reset,
    input  logic                i_ad_stby,
    input  logic                i_ad_cs,
    input  logic                i_ad_rd,
    input  logic [2:0]          i_ad_osc,
    input  logic                i_ad_range,
    input  logic                i_ad_psb_sel,
    output logic                o_ad_busy,
    output logic [P_DATA_W-1:0] o_ad_data,
    output logic                o_ad_frstdata
);

    localparam int CNT_W = $clog2(P_BUSY_CYCLES * 64 + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        READY,
        DEVRST,
        STBY
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            ptr_q, ptr_d;
    logic [12:0]           frame_q, frame_d;
    logic                  conv_q, rd_q;
    logic                  busy_q;
    logic [P_DATA_W-1:0]   data_q, data_d;
    logic                  frst_q, frst_d;

    logic                  conv_now, start, rd_rise;
    logic [2:0]            osc_eff;
    logic [CNT_W-1:0]      conv_time;
    logic                  unused_inputs;

    assign unused_inputs = i_ad_range ^ i_ad_psb_sel;

    assign conv_now  = i_ad_convstA & i_ad_convstB;
    assign start     = conv_now & ~conv_q;
    assign rd_rise   = i_ad_rd & ~rd_q;
    // Ratio code 7 is reserved on the real part; it behaves like no oversampling.
    assign osc_eff   = (i_ad_osc == 3'd7) ? 3'd0 : i_ad_osc;
    assign conv_time = CNT_W'(P_BUSY_CYCLES) << osc_eff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        frame_d = frame_q;
        data_d  = '0;
        frst_d  = 1'b0;

        if (i_ad_reset) begin
            state_d = DEVRST;
            cnt_d   = '0;
            ptr_d   = 4'd0;
            frame_d = 13'd0;
        end else if (!i_ad_stby) begin
            state_d = STBY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = CONV;
                        cnt_d   = conv_time;
                        ptr_d   = 4'd0;
                    end
                end
                CONV: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = READY;
                        cnt_d   = '0;
                        frame_d = frame_q + 13'd1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                READY: begin
                    if (start) begin
                        state_d = CONV;
                        cnt_d   = conv_time;
                        ptr_d   = 4'd0;
                    end else begin
                        if (!i_ad_cs && rd_rise && ptr_q != 4'd8) begin
                            ptr_d = ptr_q + 4'd1;
                        end
                        if (!i_ad_cs && !i_ad_rd && ptr_q < 4'd8) begin
                            data_d = P_DATA_W'({ptr_q[2:0], frame_q});
                            frst_d = (ptr_q == 4'd0);
                        end
                    end
                end
                DEVRST:  state_d = IDLE;
                STBY:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 4'd0;
            frame_q <= 13'd0;
            conv_q  <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            frst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
            conv_q  <= conv_now;
            rd_q    <= i_ad_rd;
            busy_q  <= (state_d == CONV);
            data_q  <= data_d;
            frst_q  <= frst_d;
        end
    end

    assign o_ad_busy     = busy_q;
    assign o_ad_data     = data_q;
    assign o_ad_frstdata = frst_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Scoreboard bench for ad7606_emu: stimulus pushes expected busy pulses and read
// words, independent monitors pop and compare what the emulator presents.
module tb_ad7606_emu;

    localparam int BUSY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_a = 1'b0, conv_b = 1'b0;
    logic        ad_reset = 1'b0, ad_stby = 1'b1;
    logic        cs = 1'b1, rd = 1'b1;
    logic [2:0]  ad_osc = 3'd0;
    logic        ad_range = 1'b0, ad_psb = 1'b0;
    logic        busy;
    logic [15:0] data;
    logic        frst;

    ad7606_emu #(.P_BUSY_CYCLES(BUSY), .P_DATA_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ad_convstA(conv_a), .i_ad_convstB(conv_b),
        .i_ad_reset(ad_reset), .i_ad_stby(ad_stby),
        .i_ad_cs(cs), .i_ad_rd(rd), .i_ad_osc(ad_osc),
        .i_ad_range(ad_range), .i_ad_psb_sel(ad_psb),
        .o_ad_busy(busy), .o_ad_data(data), .o_ad_frstdata(frst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    int          exp_rise_q[$];
    int          exp_len_q[$];
    logic [15:0] exp_data_q[$];
    logic        exp_frst_q[$];

    // reference model: frame count since last reset, read index, result availability
    int fr = 0;
    int ptr = 0;
    bit in_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // busy monitor: measure each pulse and match it against the next expectation
    initial begin
        logic busy_prev;
        int   rise_cyc;
        busy_prev = 1'b0;
        rise_cyc  = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) rise_cyc = cyc;
            if (!busy && busy_prev) begin
                if (exp_len_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL busy_unexpected: pulse of %0d cycles at cycle %0d, none expected",
                             cyc - rise_cyc, rise_cyc);
                end else begin
                    check("busy_rise", rise_cyc, exp_rise_q.pop_front());
                    check("busy_len", cyc - rise_cyc, exp_len_q.pop_front());
                end
            end
            busy_prev = busy;
        end
    end

    // data monitor: a strobe sampled low with cs low yields one bus word next cycle
    bit rd_smp = 1'b0;
    initial forever begin
        @(posedge clk);
        rd_smp = !cs && !rd;
    end

    initial forever begin
        @(negedge clk);
        if (rd_smp) begin
            if (exp_data_q.size() == 0) begin
                n_chk++;
                $display("FAIL read_unexpected: data 0x%0h with no expectation", data);
            end else begin
                check("rd_data", int'(data), int'(exp_data_q.pop_front()));
                check("rd_frst", int'(frst), int'(exp_frst_q.pop_front()));
            end
        end else begin
            check("idle_bus", int'({frst, data}), 0);
        end
    end

    task automatic read_pulse(input logic cs_v);
        logic [15:0] e;
        bit          hit;
        hit = !cs_v && in_ready && ptr < 8;
        cs  = cs_v;
        rd  = 1'b0;
        if (!cs_v) begin
            e = hit ? 16'((ptr << 13) | (fr % 8192)) : 16'h0000;
            exp_data_q.push_back(e);
            exp_frst_q.push_back(hit && ptr == 0);
        end
        tick(1);
        rd = 1'b1;
        tick(1);
        if (hit) ptr++;
    endtask

    // kind: 0 complete, 1 device reset, 2 block reset, 3 standby; abort_at = busy cycles before abort
    task automatic start_conv(input int osc, input int kind, input int abort_at, input int restart);
        int t, s, k;
        t = BUSY << ((osc == 7) ? 0 : osc);
        ad_osc = 3'(osc);
        conv_a = 1'b1;
        conv_b = 1'b1;
        s = cyc;
        exp_rise_q.push_back(s + 1);
        exp_len_q.push_back(kind == 0 ? t : abort_at);
        tick(1);
        conv_a = 1'b0;
        conv_b = 1'b0;
        ad_osc = 3'($urandom);
        in_ready = 1'b0;
        ptr = 0;
        if (kind != 0) begin
            tick(abort_at - 1);
            case (kind)
                1: begin ad_reset = 1'b1; tick(2); ad_reset = 1'b0; tick(1); fr = 0; end
                2: begin rst = 1'b1; tick(2); rst = 1'b0; tick(1); fr = 0; end
                default: begin ad_stby = 1'b0; tick(3); ad_stby = 1'b1; tick(1); end
            endcase
        end else begin
            if (restart > 0) begin
                tick(restart);
                conv_a = 1'b1;
                conv_b = 1'b1;
                tick(2);
                conv_a = 1'b0;
                conv_b = 1'b0;
            end
            if (t >= 16 && $urandom_range(0, 1) == 1) read_pulse(1'b0);
            k = 0;
            while (busy && k < t + 20) begin
                tick(1);
                k++;
            end
            if (k >= t + 20) begin
                n_chk++;
                $display("FAIL busy_timeout: busy still high after %0d cycles", k);
            end
            fr++;
            in_ready = 1'b1;
        end
        cs = 1'b1;
    endtask

    initial begin
        int t, nrd;
        tick(3);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(data), 0);
        check("rst_frst", int'(frst), 0);
        rst = 1'b0;
        tick(2);

        // basic conversion then a full burst plus one overrun read
        start_conv(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) read_pulse(1'b0);
        cs = 1'b1;
        tick(2);

        // long conversion with a second start edge mid-way
        start_conv(3, 0, 0, 12);
        read_pulse(1'b0);

        // device reset during a conversion, then a fresh frame 1
        start_conv(6, 1, 50, 0);
        check("devrst_busy", int'(busy), 0);
        read_pulse(1'b0);
        start_conv(0, 0, 0, 0);
        read_pulse(1'b0);
        cs = 1'b1;

        // standby blocks start edges
        ad_stby = 1'b0;
        tick(2);
        conv_a = 1'b1; conv_b = 1'b1;
        tick(2);
        conv_a = 1'b0; conv_b = 1'b0;
        tick(3);
        check("stby_busy", int'(busy), 0);
        in_ready = 1'b0;
        read_pulse(1'b0);
        ad_stby = 1'b1;
        tick(1);
        start_conv(0, 0, 0, 0);
        read_pulse(1'b0);

        // only one convst line: no conversion
        conv_a = 1'b1;
        tick(3);
        conv_a = 1'b0;
        tick(2);
        check("convA_only_busy", int'(busy), 0);

        // block reset and standby aborts
        start_conv(2, 2, 7, 0);
        read_pulse(1'b0);
        start_conv(1, 3, 3, 0);
        start_conv(7, 0, 0, 0);
        read_pulse(1'b0);
        read_pulse(1'b0);

        // randomized mix of conversions, aborts and reads
        for (int i = 0; i < 30; i++) begin
            t = $urandom_range(0, 7);
            case ($urandom_range(0, 7))
                0: start_conv(t, 1, $urandom_range(1, BUSY - 1), 0);
                1: start_conv(t, 3, $urandom_range(1, BUSY - 1), 0);
                default: start_conv(t, 0, 0, 0);
            endcase
            nrd = $urandom_range(0, 10);
            for (int j = 0; j < nrd; j++) read_pulse($urandom_range(0, 4) == 0);
            cs = 1'b1;
            tick($urandom_range(0, 3));
        end

        // frame counter wrap
        start_conv(0, 1, 2, 0);
        for (int i = 0; i < 8191; i++) start_conv(0, 0, 0, 0);
        read_pulse(1'b0);
        start_conv(0, 0, 0, 0);
        read_pulse(1'b0);
        read_pulse(1'b0);
        cs = 1'b1;

        tick(4);
        check("busy_q_drained", exp_len_q.size(), 0);
        check("data_q_drained", exp_data_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
